// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
// Contents:
//   state_t    - sequencer states (IDLE, RUN, DONE)
//   MODE_ADD   - value of 'sub' that selects a + b
//   MODE_SUB   - value of 'sub' that selects a - b
//   cnt_width  - width of the bit counter for a given operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // The counter only has to reach width-1, so $clog2(width) bits are
  // enough. A floor of one bit keeps the vector legal for tiny widths.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_sub_fa_bit.sv
// One-bit full adder assembled from two NAND-only half adders.
// Ports:
//   x, y  - operand bits
//   ci    - carry in
//   s     - sum bit
//   c     - carry out
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);

  logic n_xy;
  logic n_x;
  logic n_y;
  logic s1;
  logic n_sc;
  logic n_s;
  logic n_c;

  // First half adder: s1 = x ^ y, built as the classic four-NAND XOR.
  // n_xy doubles as the inverted carry of this stage.
  assign n_xy = ~(x & y);
  assign n_x  = ~(x & n_xy);
  assign n_y  = ~(y & n_xy);
  assign s1   = ~(n_x & n_y);

  // Second half adder folds in the carry: s = s1 ^ ci.
  assign n_sc = ~(s1 & ci);
  assign n_s  = ~(s1 & n_sc);
  assign n_c  = ~(ci & n_sc);
  assign s    = ~(n_s & n_c);

  // Both stage carries are available inverted, so their OR is one NAND.
  assign c = ~(n_xy & n_sc);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor.
// Operands are loaded on an accepted start and processed one bit per clock,
// LSB first, through a single full-adder cell with a registered carry.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted in IDLE or in the DONE cycle
//   sub    - mode sampled with start (0 = a+b, 1 = a-b)
//   a, b   - operands sampled with start
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/cout/ovf update
//   sum    - result, held until the next completion
//   cout   - carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf    - signed overflow, held with sum
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  fa_bit u_fa (
    .x  (op_a[0]),
    .y  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .c  (fa_c)
  );

  assign last_bit = (cnt == CNT_LAST);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Sequencing. DONE accepts a new request exactly like IDLE so that
  // back-to-back operations lose no cycle; any stray encoding falls
  // back to IDLE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. Subtraction is a + ~b + 1, so the inverted operand is
  // stored and the carry is preset to the mode bit. On the last
  // bit-cycle the register 'carry' still holds the carry into the MSB,
  // so overflow is that value XOR the carry out of the MSB; results are
  // committed on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= (sub == MODE_SUB) ? ~b : b;
      res   <= '0;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      res   <= {fa_s, res[WIDTH-1:1]};
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= {fa_s, res[WIDTH-1:1]};
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub at WIDTH 8, 16 and 2.
// Directed scenarios run on the 8-bit instance; the 16- and 2-bit
// instances get random add/sub traffic checked against an arithmetic model.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n;

  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        start2, sub2, busy2, done2, cout2, ovf2;
  logic [1:0]  a2, b2, sum2;

  int          sel_w;
  logic        sel_done, sel_busy, sel_cout, sel_ovf;
  logic [63:0] sel_sum;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  // View of whichever instance the current scenario is driving.
  always_comb begin
    sel_done = done8;
    sel_busy = busy8;
    sel_cout = cout8;
    sel_ovf  = ovf8;
    sel_sum  = {56'd0, sum8};
    case (sel_w)
      16: begin
        sel_done = done16; sel_busy = busy16; sel_cout = cout16;
        sel_ovf  = ovf16;  sel_sum  = {48'd0, sum16};
      end
      2: begin
        sel_done = done2; sel_busy = busy2; sel_cout = cout2;
        sel_ovf  = ovf2;  sel_sum  = {62'd0, sum2};
      end
      default: ;
    endcase
  end

  task automatic drive(input int w, input logic st, input logic s,
                       input logic [63:0] x, input logic [63:0] y);
    case (w)
      16: begin start16 = st; sub16 = s; a16 = x[15:0]; b16 = y[15:0]; end
      2:  begin start2  = st; sub2  = s; a2  = x[1:0];  b2  = y[1:0];  end
      default: begin start8 = st; sub8 = s; a8 = x[7:0]; b8 = y[7:0]; end
    endcase
  endtask

  // Issues one request and waits (bounded) for done. lat counts clock
  // edges from the accepting edge (=1) to the edge that raises done.
  // Operands are scrambled after acceptance; they must not matter.
  task automatic run_op(input int w, input logic s, input logic [63:0] x,
                        input logic [63:0] y, output int lat, output int busy_n);
    sel_w = w;
    @(negedge clk);
    drive(w, 1'b1, s, x, y);
    @(posedge clk);
    #1;
    drive(w, 1'b0, ~s, ~x, ~y);
    lat    = 1;
    busy_n = sel_busy ? 1 : 0;
    while (!sel_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (sel_busy) busy_n++;
    end
  endtask

  // Reference arithmetic on plain integers: wrapped sum, unsigned
  // carry/no-borrow, and signed range check for overflow.
  task automatic model(input int w, input logic s, input logic [63:0] x,
                       input logic [63:0] y, output logic [63:0] es,
                       output logic ec, output logic eo);
    logic [63:0] mask;
    longint      sx, sy, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    sx   = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy   = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    lim  = longint'(1) << (w - 1);
    if (s) begin
      es = (x - y) & mask;
      ec = (x >= y);
      sr = sx - sy;
    end else begin
      es = (x + y) & mask;
      ec = ((x + y) > mask);
      sr = sx + sy;
    end
    eo = (sr >= lim) || (sr < -lim);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(8, 0, 0, 0, 0);
    drive(16, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    sel_w = 8;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_add();
    int lat, bn;
    run_op(8, 1'b0, 64'h3C, 64'h45, lat, bn);
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("[TB] FAIL add_latency: got %0d, want 9", lat);
    end
    n_checks++;
    if (bn !== 8) begin
      n_fail++; $display("[TB] FAIL add_busy_cycles: got %0d, want 8", bn);
    end
    n_checks++;
    if (sum8 !== 8'h81 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL add_3C_45: got sum=%h cout=%b ovf=%b, want 81 0 1", sum8, cout8, ovf8);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h81) begin
      n_fail++;
      $display("[TB] FAIL add_single_pulse: got done=%b busy=%b sum=%h, want 0 0 81", done8, busy8, sum8);
    end
  endtask

  task automatic test_sub();
    int lat, bn;
    run_op(8, 1'b1, 64'h10, 64'h20, lat, bn);
    n_checks++;
    if (sum8 !== 8'hF0 || cout8 !== 1'b0 || ovf8 !== 1'b0 || lat !== 9) begin
      n_fail++;
      $display("[TB] FAIL sub_10_20: got sum=%h cout=%b ovf=%b lat=%0d, want F0 0 0 9",
               sum8, cout8, ovf8, lat);
    end
    run_op(8, 1'b1, 64'h80, 64'h01, lat, bn);
    n_checks++;
    if (sum8 !== 8'h7F || cout8 !== 1'b1 || ovf8 !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("[TB] FAIL sub_80_01: got sum=%h cout=%b ovf=%b lat=%0d, want 7F 1 1 9",
               sum8, cout8, ovf8, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int pulses;
    logic [7:0] held;
    sel_w = 8;
    @(negedge clk);
    drive(8, 1, 0, 64'hFF, 64'h01);
    @(posedge clk);
    #1;
    drive(8, 0, 0, 64'hFF, 64'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(8, 1, 0, 64'h55, 64'h55);
    @(negedge clk);
    drive(8, 0, 0, 64'h55, 64'h55);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done8) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("[TB] FAIL busy_ignore_pulses: got %0d, want 1", pulses);
    end
    n_checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL add_FF_01: got sum=%h cout=%b ovf=%b, want 00 1 0", sum8, cout8, ovf8);
    end
    // Operand churn while idle must leave the held result alone.
    held = sum8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(8, 0, 1'($urandom), 64'($urandom), 64'($urandom));
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sum8 !== held || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_operands: got sum=%h busy=%b done=%b, want %h 0 0",
               sum8, busy8, done8, held);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    run_op(8, 1'b0, 64'h10, 64'h20, lat, bn);
    n_checks++;
    if (sum8 !== 8'h30 || done8 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_first: got sum=%h done=%b, want 30 1", sum8, done8);
    end
    // Still inside the DONE cycle: request the next operation now.
    drive(8, 1, 0, 64'h01, 64'h02);
    @(posedge clk);
    #1;
    drive(8, 0, 0, 64'h00, 64'h00);
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_accept: got done=%b busy=%b, want 0 1", done8, busy8);
    end
    lat = 1;
    while (!done8 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== 9 || sum8 !== 8'h03 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got lat=%0d sum=%h cout=%b ovf=%b, want 9 03 0 0",
               lat, sum8, cout8, ovf8);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bn, seen_done, seen_busy;
    sel_w = 8;
    @(negedge clk);
    drive(8, 1, 0, 64'h7F, 64'h01);
    @(posedge clk);
    #1;
    drive(8, 0, 0, 64'h7F, 64'h01);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_op: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done8) seen_done++;
      if (busy8) seen_busy++;
    end
    n_checks++;
    if (seen_done !== 0 || seen_busy !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_then_idle: got done=%0d busy=%0d cycles, want 0 0", seen_done, seen_busy);
    end
    run_op(8, 1'b0, 64'h7F, 64'h01, lat, bn);
    n_checks++;
    if (sum8 !== 8'h80 || cout8 !== 1'b0 || ovf8 !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("[TB] FAIL after_reset_7F_01: got sum=%h cout=%b ovf=%b lat=%0d, want 80 0 1 9",
               sum8, cout8, ovf8, lat);
    end
  endtask

  task automatic test_random(input int w);
    int          lat, bn;
    logic        s, ec, eo;
    logic [63:0] x, y, es, mask;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      x = {32'd0, $urandom} & mask;
      y = {32'd0, $urandom} & mask;
      model(w, s, x, y, es, ec, eo);
      run_op(w, s, x, y, lat, bn);
      n_checks++;
      if (sel_sum !== es) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_sum: x=%h y=%h sub=%b got %h want %h", w, x, y, s, sel_sum, es);
      end
      n_checks++;
      if (sel_cout !== ec) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_cout: x=%h y=%h sub=%b got %b want %b", w, x, y, s, sel_cout, ec);
      end
      n_checks++;
      if (sel_ovf !== eo) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_ovf: x=%h y=%h sub=%b got %b want %b", w, x, y, s, sel_ovf, eo);
      end
      n_checks++;
      if (lat !== w + 1 || bn !== w) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_latency: got lat=%0d busy=%0d want %0d %0d", w, lat, bn, w + 1, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random(16);
    test_random(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
